// File: rtl/egd_stream_sequencer.sv
// egd_stream_sequencer: feeds firmware-written bitstream words to the Exp-Golomb decoder core.
// Ports: wb_clk_i/wb_rst_i (sync, active-high); la_wdata/la_wtoggle/la_mode word offer from LA;
//        dec_* decoder handshake (window, mode, start, done, len, value); res_* results back to LA.
module egd_stream_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [15:0]      la_wdata,
  input  logic             la_wtoggle,
  input  logic [1:0]       la_mode,
  output logic [15:0]      dec_window,
  output logic [1:0]       dec_mode,
  output logic             dec_start,
  input  logic             dec_done,
  input  logic [4:0]       dec_len,
  input  logic [7:0]       dec_value,
  output logic [7:0]       res_value,
  output logic [2:0]       res_status,
  output logic [CNT_W-1:0] res_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

  state_t     state;
  logic [31:0] bit_buf;   // MSB-first; bits below the fill level are always zero
  logic [5:0]  fill;      // 0..32 valid bits held in bit_buf
  logic        ack;
  logic        res_tog;
  logic        err;
  logic [TW-1:0] tmo_cnt;
  logic [4:0]  len_q;
  logic [7:0]  val_q;
  logic        pending;

  assign pending    = (la_wtoggle != ack);
  assign dec_window = bit_buf[31:16];
  assign res_status = {err, res_tog, ack};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      bit_buf   <= 32'h0;
      fill      <= 6'd0;
      ack       <= 1'b0;
      res_tog   <= 1'b0;
      err       <= 1'b0;
      tmo_cnt   <= '0;
      len_q     <= 5'd0;
      val_q     <= 8'h00;
      dec_mode  <= 2'b00;
      dec_start <= 1'b0;
      res_value <= 8'h00;
      res_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending && la_mode == 2'b11) begin
            bit_buf <= 32'h0;
            fill    <= 6'd0;
            err     <= 1'b0;
            ack     <= la_wtoggle;
          end else if (pending && fill <= 6'd16) begin
            // Empty region is zero, so OR-ing the word in just below the
            // current fill level appends it in stream order.
            bit_buf <= bit_buf | ({la_wdata, 16'h0000} >> fill);
            fill    <= fill + 6'd16;
            ack     <= la_wtoggle;
          end else if (fill >= 6'd16 && !err) begin
            state     <= ISSUE;
            dec_mode  <= la_mode;
            dec_start <= 1'b1;
          end
        end
        ISSUE: begin
          dec_start <= 1'b0;
          tmo_cnt   <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (dec_done) begin
            if (dec_len >= 5'd1 && dec_len <= 5'd16) begin
              len_q <= dec_len;
              val_q <= dec_value;
              state <= COMMIT;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        COMMIT: begin
          // len <= 16 <= fill here, so fill cannot underflow.
          bit_buf   <= bit_buf << len_q;
          fill      <= fill - {1'b0, len_q};
          res_value <= val_q;
          res_tog   <= ~res_tog;
          res_count <= res_count + {{(CNT_W-1){1'b0}}, 1'b1};
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_egd_stream_sequencer.sv
module tb_egd_stream_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [15:0] la_wdata = 16'h0;
  logic        la_wtoggle = 1'b0;
  logic [1:0]  la_mode = 2'b00;
  logic [15:0] dec_window;
  logic [1:0]  dec_mode;
  logic        dec_start;
  logic        dec_done = 1'b0;
  logic [4:0]  dec_len = 5'd0;
  logic [7:0]  dec_value = 8'h0;
  logic [7:0]  res_value;
  logic [2:0]  res_status;
  logic [3:0]  res_count;

  int n_tests = 0;
  int n_fail  = 0;

  egd_stream_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .la_wdata(la_wdata), .la_wtoggle(la_wtoggle), .la_mode(la_mode),
    .dec_window(dec_window), .dec_mode(dec_mode), .dec_start(dec_start),
    .dec_done(dec_done), .dec_len(dec_len), .dec_value(dec_value),
    .res_value(res_value), .res_status(res_status), .res_count(res_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end at a negedge.
  task automatic do_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1; la_wtoggle = 1'b0; la_mode = 2'b00; dec_done = 1'b0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  task automatic offer(input logic [15:0] d, input logic [1:0] m);
    la_wdata = d; la_mode = m; la_wtoggle = ~la_wtoggle;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge wb_clk_i);
      if (dec_start === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic dec_pulse(input logic [4:0] len, input logic [7:0] val);
    @(negedge wb_clk_i);
    dec_done = 1'b1; dec_len = len; dec_value = val;
    @(negedge wb_clk_i);
    dec_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({dec_window, dec_mode, dec_start, res_value, res_status, res_count} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got win=%h mode=%h start=%b val=%h st=%b cnt=%h, expected all 0",
               dec_window, dec_mode, dec_start, res_value, res_status, res_count);
    end
  endtask

  task automatic test_single_word();
    bit ok;
    do_reset();
    offer(16'h8000, 2'b00);
    @(negedge wb_clk_i);
    n_tests++;
    if (res_status[0] !== la_wtoggle || dec_start !== 1'b0) begin
      n_fail++; $display("FAIL single_ack: got ack=%b start=%b expected ack=%b start=0", res_status[0], dec_start, la_wtoggle);
    end
    @(negedge wb_clk_i);
    n_tests++;
    if (dec_start !== 1'b1 || dec_window !== 16'h8000 || dec_mode !== 2'b00) begin
      n_fail++; $display("FAIL single_issue: got start=%b win=%h mode=%h expected 1 8000 0", dec_start, dec_window, dec_mode);
    end
    @(negedge wb_clk_i);
    n_tests++;
    if (dec_start !== 1'b0 || dec_window !== 16'h8000) begin
      n_fail++; $display("FAIL single_pulse_width: got start=%b win=%h expected 0 8000", dec_start, dec_window);
    end
    dec_pulse(5'd1, 8'h00);
    @(negedge wb_clk_i);
    n_tests++;
    if (res_value !== 8'h00 || res_status !== 3'b011 || res_count !== 4'd1) begin
      n_fail++; $display("FAIL single_commit: got val=%h st=%b cnt=%0d expected 00 011 1", res_value, res_status, res_count);
    end
    // 15 bits left: below the issue threshold, and all zero after the shift.
    wait_start(8, ok);
    n_tests++;
    if (ok || dec_window !== 16'h0000) begin
      n_fail++; $display("FAIL single_fill15_idle: got start_seen=%b win=%h expected 0 0000", ok, dec_window);
    end
    offer(16'hABCD, 2'b00);
    wait_start(6, ok);
    n_tests++;
    if (!ok || dec_window !== 16'h0001) begin
      n_fail++; $display("FAIL single_append_at_15: got start_seen=%b win=%h expected 1 0001", ok, dec_window);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    offer(16'hFFFF, 2'b00);
    @(negedge wb_clk_i);
    offer(16'h1234, 2'b00);
    @(negedge wb_clk_i);
    n_tests++;
    if (res_status[0] !== la_wtoggle) begin
      n_fail++; $display("FAIL bp_two_acked: got ack=%b expected %b", res_status[0], la_wtoggle);
    end
    wait_start(4, ok);
    n_tests++;
    if (!ok || dec_window !== 16'hFFFF) begin
      n_fail++; $display("FAIL bp_first_issue: got start_seen=%b win=%h expected 1 ffff", ok, dec_window);
    end
    offer(16'hAAAA, 2'b00);
    repeat (6) @(negedge wb_clk_i);
    n_tests++;
    if (res_status[0] !== ~la_wtoggle) begin
      n_fail++; $display("FAIL bp_no_ack_in_wait: got ack=%b expected %b", res_status[0], ~la_wtoggle);
    end
    dec_pulse(5'd4, 8'h01);
    wait_start(6, ok);
    n_tests++;
    if (!ok || dec_window !== 16'hFFF1 || res_status[0] !== ~la_wtoggle) begin
      n_fail++; $display("FAIL bp_fill28_no_ack: got start_seen=%b win=%h ack=%b expected 1 fff1 %b",
                         ok, dec_window, res_status[0], ~la_wtoggle);
    end
    dec_pulse(5'd12, 8'h02);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    n_tests++;
    if (res_status[0] !== la_wtoggle || dec_window !== 16'h1234 || res_count !== 4'd2) begin
      n_fail++; $display("FAIL bp_fill16_ack: got ack=%b win=%h cnt=%0d expected %b 1234 2",
                         res_status[0], dec_window, res_count, la_wtoggle);
    end
  endtask

  task automatic test_shift_align();
    bit ok;
    do_reset();
    offer(16'h00A5, 2'b01);
    @(negedge wb_clk_i);
    offer(16'hF000, 2'b01);
    wait_start(6, ok);
    n_tests++;
    if (!ok || dec_window !== 16'h00A5 || dec_mode !== 2'b01) begin
      n_fail++; $display("FAIL shift_first: got start_seen=%b win=%h mode=%h expected 1 00a5 1", ok, dec_window, dec_mode);
    end
    dec_pulse(5'd5, 8'h3C);
    wait_start(6, ok);
    n_tests++;
    if (!ok || dec_window !== 16'h14BE || res_value !== 8'h3C || res_count !== 4'd1) begin
      n_fail++; $display("FAIL shift_len5: got start_seen=%b win=%h val=%h cnt=%0d expected 1 14be 3c 1",
                         ok, dec_window, res_value, res_count);
    end
  endtask

  task automatic test_bad_len();
    bit ok;
    do_reset();
    offer(16'h8000, 2'b10);
    wait_start(6, ok);
    n_tests++;
    if (!ok || dec_mode !== 2'b10) begin
      n_fail++; $display("FAIL bad_issue: got start_seen=%b mode=%h expected 1 2", ok, dec_mode);
    end
    dec_pulse(5'd0, 8'h09);
    n_tests++;
    if (res_status[2] !== 1'b1 || res_count !== 4'd0 || res_status[1] !== 1'b0) begin
      n_fail++; $display("FAIL bad_len0_err: got st=%b cnt=%0d expected err=1 tog=0 cnt=0", res_status, res_count);
    end
    wait_start(10, ok);
    n_tests++;
    if (ok) begin
      n_fail++; $display("FAIL bad_no_issue: got start_seen=1 expected 0");
    end
    offer(16'h1111, 2'b00);
    @(negedge wb_clk_i);
    n_tests++;
    if (res_status[0] !== la_wtoggle) begin
      n_fail++; $display("FAIL bad_word_accepted: got ack=%b expected %b", res_status[0], la_wtoggle);
    end
    offer(16'h0000, 2'b11);
    @(negedge wb_clk_i);
    n_tests++;
    if (res_status !== {2'b00, la_wtoggle} || dec_window !== 16'h0000 || res_count !== 4'd0) begin
      n_fail++; $display("FAIL bad_flush: got st=%b win=%h cnt=%0d expected %b 0000 0",
                         res_status, dec_window, res_count, {2'b00, la_wtoggle});
    end
    offer(16'hC000, 2'b00);
    wait_start(6, ok);
    dec_pulse(5'd17, 8'h00);
    n_tests++;
    if (!ok || res_status[2] !== 1'b1 || res_count !== 4'd0) begin
      n_fail++; $display("FAIL bad_len17_err: got start_seen=%b err=%b cnt=%0d expected 1 1 0", ok, res_status[2], res_count);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    offer(16'h8000, 2'b00);
    wait_start(6, ok);
    repeat (64) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    n_tests++;
    if (!ok || res_status[2] !== 1'b0) begin
      n_fail++; $display("FAIL timeout_not_early: got start_seen=%b err=%b expected 1 0", ok, res_status[2]);
    end
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    n_tests++;
    if (res_status[2] !== 1'b1) begin
      n_fail++; $display("FAIL timeout_at_64: got err=%b expected 1", res_status[2]);
    end
    dec_pulse(5'd3, 8'h55);
    wait_start(8, ok);
    n_tests++;
    if (ok || res_value !== 8'h00 || res_count !== 4'd0 || res_status !== 3'b101) begin
      n_fail++; $display("FAIL timeout_late_done: got start_seen=%b val=%h cnt=%0d st=%b expected 0 00 0 101",
                         ok, res_value, res_count, res_status);
    end
  endtask

  task automatic test_wrap_and_reset();
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      offer(16'hFFFF, 2'b00);
      wait_start(6, ok);
      dec_pulse(5'd16, 8'(i + 1));
      @(negedge wb_clk_i);
      n_tests++;
      if (!ok || res_count !== 4'((i + 1) % 16) || res_value !== 8'(i + 1)) begin
        n_fail++; $display("FAIL wrap_commit_%0d: got start_seen=%b cnt=%0d val=%h expected 1 %0d %h",
                           i, ok, res_count, res_value, (i + 1) % 16, 8'(i + 1));
      end
    end
    offer(16'h8000, 2'b01);
    wait_start(6, ok);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1; la_wtoggle = 1'b0;
    @(negedge wb_clk_i);
    n_tests++;
    if (!ok || {dec_window, dec_mode, dec_start, res_value, res_status, res_count} !== 38'h0) begin
      n_fail++; $display("FAIL reset_mid_wait: got start_seen=%b win=%h mode=%h val=%h st=%b cnt=%h expected 1 and all 0",
                         ok, dec_window, dec_mode, res_value, res_status, res_count);
    end
    wb_rst_i = 1'b0;
    dec_pulse(5'd1, 8'h77);
    @(negedge wb_clk_i);
    n_tests++;
    if ({dec_start, res_value, res_status, res_count} !== 16'h0) begin
      n_fail++; $display("FAIL reset_late_done: got start=%b val=%h st=%b cnt=%h expected all 0",
                         dec_start, res_value, res_status, res_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_shift_align();
    test_bad_len();
    test_timeout();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
